// File: rtl/ebus_pkg.sv
// Shared types for the EBUS arbiter: arbitration mode and FSM state encodings.
package ebus_pkg;

  typedef enum logic {
    FIXED  = 1'b0,
    RROBIN = 1'b1
  } ebus_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } ebus_state_e;

  // True when more than one bit of a (zero-extended) request vector is set.
  function automatic logic multi_hot(input logic [15:0] vec);
    return (vec & (vec - 16'd1)) != 16'd0;
  endfunction

endpackage

// File: rtl/ebus_prio_pick.sv
// Rotating priority encoder: first set bit of req at or after start, wrapping modulo N.
module ebus_prio_pick #(
  parameter int N  = 11,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] winner,
  output logic          found
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, start} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/ebus_arbiter.sv
// EBUS arbiter: grants one driver at a time, registers its data onto the bus,
// and keeps sticky contention/timeout diagnostics.
//
//   state | meaning
//   IDLE  | no owner; any eligible driver is granted on the next edge
//   OWNED | owner drives busData; handoff on owner release or hold timeout
module ebus_arbiter
  import ebus_pkg::*;
#(
  parameter int         NDRV    = 11,
  parameter int         WIDTH   = 36,
  parameter ebus_mode_e MODE    = FIXED,
  parameter int         TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          CROBAR_n,
  input  logic [NDRV-1:0]               driving,
  input  logic [NDRV-1:0][0:WIDTH-1]    drvData,
  input  logic                          errClr,
  output logic [0:WIDTH-1]              busData,
  output logic                          busValid,
  output logic [NDRV-1:0]               grant,
  output logic [$clog2(NDRV)-1:0]       owner,
  output logic                          contentionErr,
  output logic [NDRV-1:0]               contentionMask,
  output logic                          timeoutErr
);

  localparam int OW = $clog2(NDRV);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  ebus_state_e     state;
  logic [NDRV-1:0] blocked;
  logic [OW-1:0]   last_owner;
  logic [CW-1:0]   hold_cnt;

  logic [NDRV-1:0] eligible;
  logic [NDRV-1:0] pick_req;
  logic [OW-1:0]   start;
  logic [OW-1:0]   winner;
  logic            found;
  logic            owner_drop;
  logic            timeout_hit;
  logic            rearb;
  logic            contention;

  assign eligible    = driving & ~blocked;
  assign owner_drop  = (state == OWNED) && !driving[owner];
  assign timeout_hit = (TIMEOUT != 0) && (state == OWNED) && driving[owner] &&
                       (hold_cnt == CW'(TIMEOUT - 1));
  assign rearb       = (state == IDLE) || owner_drop || timeout_hit;

  // grant is the owner one-hot, so it masks the revoked driver out of this edge's pick
  assign pick_req    = timeout_hit ? (eligible & ~grant) : eligible;
  assign start       = (MODE == RROBIN) ?
                       ((last_owner == OW'(NDRV - 1)) ? '0 : last_owner + OW'(1)) : '0;
  assign contention  = multi_hot(16'(eligible));

  ebus_prio_pick #(
    .N  (NDRV),
    .IW (OW)
  ) u_pick (
    .req    (pick_req),
    .start  (start),
    .winner (winner),
    .found  (found)
  );

  always_ff @(posedge clk or negedge CROBAR_n) begin
    if (!CROBAR_n) begin
      state      <= IDLE;
      busData    <= '0;
      busValid   <= 1'b0;
      grant      <= '0;
      owner      <= '0;
      hold_cnt   <= '0;
      last_owner <= OW'(NDRV - 1);
    end else if (rearb) begin
      hold_cnt <= '0;
      if (found) begin
        state      <= OWNED;
        busData    <= drvData[winner];
        busValid   <= 1'b1;
        grant      <= {{(NDRV-1){1'b0}}, 1'b1} << winner;
        owner      <= winner;
        last_owner <= winner;
      end else begin
        state    <= IDLE;
        busData  <= '0;
        busValid <= 1'b0;
        grant    <= '0;
        owner    <= '0;
      end
    end else begin
      busData  <= drvData[owner];
      hold_cnt <= hold_cnt + CW'(1);
    end
  end

  // A revoked driver stays out until it releases its request at least once.
  always_ff @(posedge clk or negedge CROBAR_n) begin
    if (!CROBAR_n) begin
      blocked <= '0;
    end else begin
      blocked <= (blocked & driving) | (timeout_hit ? grant : '0);
    end
  end

  always_ff @(posedge clk or negedge CROBAR_n) begin
    if (!CROBAR_n) begin
      contentionErr  <= 1'b0;
      contentionMask <= '0;
      timeoutErr     <= 1'b0;
    end else begin
      contentionErr  <= contention | (contentionErr & ~errClr);
      contentionMask <= (contention ? driving : '0) | (errClr ? '0 : contentionMask);
      timeoutErr     <= timeout_hit | (timeoutErr & ~errClr);
    end
  end

endmodule

// File: tb/tb_ebus_arbiter.sv
// Directed bench for ebus_arbiter: fixed-priority, round-robin and timeout instances.
module tb_ebus_arbiter;
  import ebus_pkg::*;

  logic clk;
  logic rst_n;

  logic [10:0]         f_drv;
  logic [10:0][0:35]   f_data;
  logic                f_clr;
  logic [0:35]         f_bus;
  logic                f_valid;
  logic [10:0]         f_grant;
  logic [3:0]          f_owner;
  logic                f_cerr;
  logic [10:0]         f_cmask;
  logic                f_terr;

  logic [3:0]          t_drv;
  logic [3:0][0:7]     t_data;
  logic                t_clr;
  logic [0:7]          t_bus;
  logic                t_valid;
  logic [3:0]          t_grant;
  logic [1:0]          t_owner;
  logic                t_cerr;
  logic [3:0]          t_cmask;
  logic                t_terr;

  logic [3:0]          r_drv;
  logic [3:0][0:7]     r_data;
  logic                r_clr;
  logic [0:7]          r_bus;
  logic                r_valid;
  logic [3:0]          r_grant;
  logic [1:0]          r_owner;
  logic                r_cerr;
  logic [3:0]          r_cmask;
  logic                r_terr;

  int nvec;
  int nmis;

  ebus_arbiter #(.NDRV(11), .WIDTH(36), .MODE(FIXED), .TIMEOUT(0)) u_fix (
    .clk(clk), .CROBAR_n(rst_n), .driving(f_drv), .drvData(f_data), .errClr(f_clr),
    .busData(f_bus), .busValid(f_valid), .grant(f_grant), .owner(f_owner),
    .contentionErr(f_cerr), .contentionMask(f_cmask), .timeoutErr(f_terr)
  );

  ebus_arbiter #(.NDRV(4), .WIDTH(8), .MODE(FIXED), .TIMEOUT(4)) u_to (
    .clk(clk), .CROBAR_n(rst_n), .driving(t_drv), .drvData(t_data), .errClr(t_clr),
    .busData(t_bus), .busValid(t_valid), .grant(t_grant), .owner(t_owner),
    .contentionErr(t_cerr), .contentionMask(t_cmask), .timeoutErr(t_terr)
  );

  ebus_arbiter #(.NDRV(4), .WIDTH(8), .MODE(RROBIN), .TIMEOUT(0)) u_rr (
    .clk(clk), .CROBAR_n(rst_n), .driving(r_drv), .drvData(r_data), .errClr(r_clr),
    .busData(r_bus), .busValid(r_valid), .grant(r_grant), .owner(r_owner),
    .contentionErr(r_cerr), .contentionMask(r_cmask), .timeoutErr(r_terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    nvec  = 0;
    nmis  = 0;
    rst_n = 1'b1;
    f_drv = '0; f_clr = 1'b0;
    t_drv = '0; t_clr = 1'b0;
    r_drv = '0; r_clr = 1'b0;
    for (int i = 0; i < 11; i++) f_data[i] = 36'(i);
    for (int i = 0; i < 4; i++) begin
      t_data[i] = 8'(8'h10 + i);
      r_data[i] = 8'(8'hA0 + i);
    end
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_valid", f_valid, 0);
    chk("rst_grant", f_grant, 0);
    chk("rst_owner", f_owner, 0);
    chk("rst_bus",   f_bus,   0);
    chk("rst_errs",  {f_cerr, f_terr, f_cmask}, 0);
    chk("rst_rr",    {r_valid, r_grant}, 0);

    // two drivers rise together: lowest wins, contention recorded
    f_drv = 11'h088;
    tick();
    chk("fix_grant3", f_grant, 11'h008);
    chk("fix_owner3", f_owner, 3);
    chk("fix_bus3",   f_bus,   3);
    chk("fix_cerr",   f_cerr,  1);
    chk("fix_cmask",  f_cmask, 11'h088);
    f_drv = 11'h080;
    tick();
    chk("fix_grant7", f_grant, 11'h080);
    chk("fix_bus7",   f_bus,   7);
    chk("fix_valid7", f_valid, 1);
    f_data[7] = 36'hABC;
    tick();
    chk("fix_reload", f_bus, 36'hABC);
    f_drv = 11'h082;
    tick();
    chk("fix_nopreempt", f_grant, 11'h080);
    f_drv = 11'h000;
    tick();
    chk("fix_idle", {f_valid, f_grant, f_owner}, 0);
    chk("fix_idle_bus", f_bus, 0);

    // errClr alone clears; errClr with a new contention loses to the set
    f_clr = 1'b1;
    tick();
    chk("clr_cerr",  f_cerr,  0);
    chk("clr_cmask", f_cmask, 0);
    f_drv = 11'h006;
    tick();
    f_clr = 1'b0;
    chk("clrset_cerr",  f_cerr,  1);
    chk("clrset_cmask", f_cmask, 11'h006);
    chk("clrset_grant", f_grant, 11'h002);
    f_drv = 11'h000;
    f_clr = 1'b1;
    tick();
    f_clr = 1'b0;
    chk("clr_all", {f_cerr, f_terr, f_cmask}, 0);

    // round robin: owner releases for one cycle each time
    r_drv = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_owner", r_owner, seq[i]);
      chk("rr_bus",   r_bus,   8'hA0 + seq[i]);
      r_drv = 4'hF & ~(4'b0001 << seq[i]);
    end
    r_drv = 4'h0;
    tick();
    chk("rr_idle", r_valid, 0);

    // hold timeout after four owned cycles, then blocked until release
    t_drv = 4'b0100;
    tick();
    chk("to_grant", t_grant, 4'b0100);
    repeat (3) tick();
    chk("to_still",  {t_terr, t_grant}, 5'b0_0100);
    tick();
    chk("to_terr",   t_terr,  1);
    chk("to_revoke", {t_valid, t_grant}, 0);
    chk("to_bus0",   t_bus,   0);
    tick();
    chk("to_blocked", t_grant, 0);
    t_drv = 4'b0000;
    tick();
    t_drv = 4'b0100;
    t_clr = 1'b1;
    tick();
    t_clr = 1'b0;
    chk("to_regrant", t_grant, 4'b0100);
    chk("to_clr",     t_terr,  0);
    t_drv = 4'b0110;
    repeat (3) tick();
    chk("to_hold2", t_grant, 4'b0100);
    tick();
    chk("to_handoff", t_grant, 4'b0010);
    chk("to_bus1",    t_bus,   8'h11);
    chk("to_terr2",   t_terr,  1);
    t_drv = 4'b0000;
    tick();

    // asynchronous reset mid-ownership
    f_drv = 11'h010;
    tick();
    chk("ar_grant4", f_grant, 11'h010);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_grant", f_grant, 0);
    chk("ar_valid", f_valid, 0);
    chk("ar_bus",   f_bus,   0);
    chk("ar_owner", f_owner, 0);
    f_drv = 11'h020;
    #2 rst_n = 1'b1;
    tick();
    chk("ar_first", f_grant, 11'h020);
    chk("ar_bus5",  f_bus,   5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
